// File: rtl/bbox_pkg.sv
// Shared types and helpers for the bounding-box engine: FSM states, luma and
// coordinate-width calculation.
package bbox_pkg;

  typedef enum logic [1:0] {
    SCAN = 2'd0,
    LAST = 2'd1,
    DONE = 2'd2
  } bbox_state_e;

  localparam int unsigned DEF_IMG_W  = 768;
  localparam int unsigned DEF_IMG_H  = 512;
  localparam int unsigned DEF_PIX_W  = 24;
  localparam int unsigned DEF_THRESH = 128;

  // Width of a coordinate able to hold 0..n-1; never less than one bit.
  function automatic int unsigned coord_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // (R + 2G + B) / 4, summed at 10 bits so the full range cannot overflow.
  function automatic logic [7:0] luma(input logic [23:0] pix);
    logic [9:0] sum;
    sum = {2'b00, pix[23:16]} + {1'b0, pix[15:8], 1'b0} + {2'b00, pix[7:0]};
    return sum[9:2];
  endfunction

endpackage

// File: rtl/bbox_pixel_classifier.sv
// Combinational foreground test for one RGB pixel.
module bbox_pixel_classifier
  import bbox_pkg::*;
#(
  parameter int unsigned THRESH = DEF_THRESH
) (
  input  logic [23:0] pix,
  output logic        fg
);

  logic [7:0] luma_val;

  always_comb begin
    luma_val = luma(pix);
    fg       = (luma_val >= 8'(THRESH));
  end

endmodule

// File: rtl/bounding_box_top.sv
// Raster-scans an internal RGB image once after reset and reports the smallest
// axis-aligned box enclosing every foreground pixel.
module bounding_box_top
  import bbox_pkg::*;
#(
  parameter int unsigned IMG_W  = DEF_IMG_W,
  parameter int unsigned IMG_H  = DEF_IMG_H,
  parameter int unsigned PIX_W  = DEF_PIX_W,
  parameter int unsigned THRESH = DEF_THRESH
) (
  input  logic                        CLOCK_50,
  input  logic                        rst,
  output logic                        done,
  output logic                        found,
  output logic [coord_w(IMG_W)-1:0]   min_x,
  output logic [coord_w(IMG_W)-1:0]   max_x,
  output logic [coord_w(IMG_H)-1:0]   min_y,
  output logic [coord_w(IMG_H)-1:0]   max_y
);

  localparam int unsigned NPIX = IMG_W * IMG_H;
  localparam int unsigned AW   = coord_w(NPIX);
  localparam int unsigned XW   = coord_w(IMG_W);
  localparam int unsigned YW   = coord_w(IMG_H);

  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
  localparam logic [XW-1:0] X_MAX     = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_MAX     = YW'(IMG_H - 1);

  // Loaded only from outside through the hierarchy; never written here.
  logic [PIX_W-1:0] ram [0:NPIX-1];

  bbox_state_e      state_q;
  logic [AW-1:0]    addr_q;
  logic [XW-1:0]    x_q, pix_x_q;
  logic [YW-1:0]    y_q, pix_y_q;
  logic             rd_valid_q;
  logic [PIX_W-1:0] rd_data_q;
  logic             done_q, found_q;
  logic [XW-1:0]    min_x_q, max_x_q;
  logic [YW-1:0]    min_y_q, max_y_q;
  logic             fg, eval_en;

  always_ff @(posedge CLOCK_50) begin
    rd_data_q <= ram[addr_q];
  end

  bbox_pixel_classifier #(
    .THRESH (THRESH)
  ) u_classifier (
    .pix (rd_data_q[23:0]),
    .fg  (fg)
  );

  // rd_data_q holds the pixel issued on the previous edge, tagged by pix_x_q/pix_y_q.
  assign eval_en = ((state_q == SCAN) && rd_valid_q) || (state_q == LAST);

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      state_q    <= SCAN;
      addr_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      pix_x_q    <= '0;
      pix_y_q    <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      found_q    <= 1'b0;
      min_x_q    <= X_MAX;
      min_y_q    <= Y_MAX;
      max_x_q    <= '0;
      max_y_q    <= '0;
    end else begin
      unique case (state_q)
        SCAN: begin
          rd_valid_q <= 1'b1;
          pix_x_q    <= x_q;
          pix_y_q    <= y_q;
          if (addr_q == LAST_ADDR) begin
            state_q <= LAST;
          end else begin
            addr_q <= addr_q + 1'b1;
            if (x_q == X_MAX) begin
              x_q <= '0;
              y_q <= y_q + 1'b1;
            end else begin
              x_q <= x_q + 1'b1;
            end
          end
        end
        LAST:    state_q <= DONE;
        DONE:    done_q  <= 1'b1;
        default: state_q <= DONE;
      endcase

      if (eval_en && fg) begin
        found_q <= 1'b1;
        if (pix_x_q < min_x_q) min_x_q <= pix_x_q;
        if (pix_x_q > max_x_q) max_x_q <= pix_x_q;
        if (pix_y_q < min_y_q) min_y_q <= pix_y_q;
        if (pix_y_q > max_y_q) max_y_q <= pix_y_q;
      end
    end
  end

  // Hide the reset sentinels until a foreground pixel has been seen.
  always_comb begin
    done  = done_q;
    found = found_q;
    min_x = found_q ? min_x_q : '0;
    max_x = found_q ? max_x_q : '0;
    min_y = found_q ? min_y_q : '0;
    max_y = found_q ? max_y_q : '0;
  end

endmodule

// File: tb/tb_bounding_box_top.sv
// Self-checking bench for bounding_box_top on an 8x4 image: table of images with
// expected boxes through a scoreboard queue, plus mid-scan reset sequences.
module tb_bounding_box_top;

  localparam int unsigned W    = 8;
  localparam int unsigned H    = 4;
  localparam int unsigned NPIX = W * H;
  localparam int          LAT  = NPIX + 2;

  logic       CLOCK_50 = 1'b0;
  logic       rst      = 1'b1;
  logic       done, found;
  logic [2:0] min_x, max_x;
  logic [1:0] min_y, max_y;

  bounding_box_top #(
    .IMG_W  (W),
    .IMG_H  (H),
    .PIX_W  (24),
    .THRESH (128)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .rst      (rst),
    .done     (done),
    .found    (found),
    .min_x    (min_x),
    .max_x    (max_x),
    .min_y    (min_y),
    .max_y    (max_y)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int          a0;
    logic [23:0] p0;
    int          a1;
    logic [23:0] p1;
    bit          found;
    int          mnx, mxx, mny, mxy;
  } vec_t;

  typedef struct {
    string name;
    bit    found;
    int    mnx, mxx, mny, mxy;
  } exp_t;

  vec_t vecs [6];
  exp_t sb_q [$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load(input int a0, input logic [23:0] p0, input int a1,
                      input logic [23:0] p1);
    for (int i = 0; i < int'(NPIX); i++) dut.ram[i] = 24'h0;
    dut.ram[a0] = p0;
    dut.ram[a1] = p1;
  endtask

  task automatic chk_outputs(input string tag, input exp_t e);
    chk({tag, ".found"}, int'(found), int'(e.found));
    chk({tag, ".min_x"}, int'(min_x), e.mnx);
    chk({tag, ".max_x"}, int'(max_x), e.mxx);
    chk({tag, ".min_y"}, int'(min_y), e.mny);
    chk({tag, ".max_y"}, int'(max_y), e.mxy);
  endtask

  // Release reset on a falling edge and count rising edges until done is seen.
  task automatic release_and_wait(input string tag);
    int   lat;
    exp_t e;
    @(negedge CLOCK_50);
    rst = 1'b0;
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      if (done) begin
        lat = i;
        break;
      end
    end
    chk({tag, ".latency"}, lat, LAT);
    if (sb_q.size() == 0) begin
      chk({tag, ".scoreboard_empty"}, 1, 0);
    end else begin
      e = sb_q.pop_front();
      chk_outputs(e.name, e);
      repeat (5) @(negedge CLOCK_50);
      chk({tag, ".done_held"}, int'(done), 1);
      chk_outputs({e.name, ".frozen"}, e);
    end
  endtask

  task automatic reset_hold();
    @(negedge CLOCK_50);
    rst = 1'b1;
    repeat (2) @(negedge CLOCK_50);
  endtask

  task automatic chk_reset_state(input string tag);
    exp_t z;
    z = '{name: tag, found: 1'b0, mnx: 0, mxx: 0, mny: 0, mxy: 0};
    chk({tag, ".done"}, int'(done), 0);
    chk_outputs(tag, z);
  endtask

  initial begin
    exp_t e;
    // a0, p0, a1, p1, found, min_x, max_x, min_y, max_y ; address = y*8 + x
    vecs[0] = '{0,  24'h000000, 0,  24'h000000, 1'b0, 0, 0, 0, 0};  // empty
    vecs[1] = '{19, 24'hFFFFFF, 19, 24'hFFFFFF, 1'b1, 3, 3, 2, 2};  // (3,2)
    vecs[2] = '{1,  24'hFFFFFF, 30, 24'h808080, 1'b1, 1, 6, 0, 3};  // (1,0),(6,3)
    vecs[3] = '{13, 24'h808080, 18, 24'h7F7F7F, 1'b1, 5, 5, 1, 1};  // luma 128 vs 127
    vecs[4] = '{0,  24'hFF00FF, 31, 24'h00FF00, 1'b0, 0, 0, 0, 0};  // both luma 127
    vecs[5] = '{0,  24'hFF80FF, 31, 24'hFFFFFF, 1'b1, 0, 7, 0, 3};  // corners

    repeat (2) @(negedge CLOCK_50);
    chk_reset_state("reset");

    for (int v = 0; v < 6; v++) begin
      reset_hold();
      load(vecs[v].a0, vecs[v].p0, vecs[v].a1, vecs[v].p1);
      e = '{name: $sformatf("vec%0d", v), found: vecs[v].found, mnx: vecs[v].mnx,
            mxx: vecs[v].mxx, mny: vecs[v].mny, mxy: vecs[v].mxy};
      sb_q.push_back(e);
      release_and_wait($sformatf("vec%0d", v));
    end

    // Abort at cycle 15, before the foreground pixel has been evaluated.
    reset_hold();
    load(19, 24'hFFFFFF, 19, 24'hFFFFFF);
    @(negedge CLOCK_50);
    rst = 1'b0;
    repeat (15) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("abort15.done_before", int'(done), 0);
    rst = 1'b1;
    #1;
    chk_reset_state("abort15");
    repeat (2) @(negedge CLOCK_50);
    sb_q.push_back('{name: "restart15", found: 1'b1, mnx: 3, mxx: 3, mny: 2, mxy: 2});
    release_and_wait("restart15");

    // Abort at cycle 25, after (3,2) was accumulated: running outputs, then cleared.
    reset_hold();
    @(negedge CLOCK_50);
    rst = 1'b0;
    repeat (25) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("abort25.done_before", int'(done), 0);
    chk_outputs("abort25.running",
                '{name: "", found: 1'b1, mnx: 3, mxx: 3, mny: 2, mxy: 2});
    rst = 1'b1;
    #1;
    chk_reset_state("abort25");
    repeat (2) @(negedge CLOCK_50);
    sb_q.push_back('{name: "restart25", found: 1'b1, mnx: 3, mxx: 3, mny: 2, mxy: 2});
    release_and_wait("restart25");

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bounding_box_top.md
Name: bounding_box_top

Overview:
Self-contained image bounding-box engine. It holds an RGB image in an internal memory that the simulation loads by hierarchical $readmemh. After reset it scans every pixel once in raster order and reports the smallest axis-aligned box that encloses all foreground pixels. It raises done when the scan is complete.

Parameters:
IMG_W, 768, image width in pixels
IMG_H, 512, image height in pixels
PIX_W, 24, pixel width; bits 23:16 are R, 15:8 are G, 7:0 are B
THRESH, 128, foreground luma threshold (8-bit)

Ports:
CLOCK_50  in   1  system clock, rising-edge
rst       in   1  asynchronous active-high reset
done      out  1  scan complete; held high until the next reset
found     out  1  at least one foreground pixel exists; valid when done=1
min_x     out  $clog2(IMG_W)  left edge of box
max_x     out  $clog2(IMG_W)  right edge of box
min_y     out  $clog2(IMG_H)  top edge of box
max_y     out  $clog2(IMG_H)  bottom edge of box

Behaviour:
- Internal array named exactly "ram": logic [PIX_W-1:0] ram [0:IMG_W*IMG_H-1].
  - Row-major layout: address = y*IMG_W + x.
  - No write port; contents are only loaded by hierarchical $readmemh.
  - Reset never clears ram.
  - Synchronous read with 1-cycle latency.
- Foreground test: luma = (R + 2*G + B) >> 2, computed at 10 bits and then truncated to 8. A pixel is foreground iff luma >= THRESH.
- FSM has states SCAN, LAST, DONE.
  - rst=1 asynchronously forces SCAN with: addr=0, x=y=0, done=0, found=0, min_x=IMG_W-1, min_y=IMG_H-1, max_x=0, max_y=0.
  - SCAN: each cycle issue addr; the pixel read the previous cycle is evaluated with its registered (x,y).
    - x increments each cycle and wraps to 0 at IMG_W-1; when x wraps, y increments.
    - After issuing address IMG_W*IMG_H-1, go to LAST.
  - LAST: evaluate the final pixel, then go to DONE.
  - DONE: done=1, and all other registers are frozen until rst.
- Accumulation on a foreground pixel:
  - found<=1
  - min_x<=min(min_x,x), max_x<=max(max_x,x)
  - min_y<=min(min_y,y), max_y<=max(max_y,y)
- Timing: let edge 1 be the first rising edge after rst falls.
  - Address p is issued at edge p+1.
  - Pixel p is evaluated at edge p+2.
  - done is high after edge N+2, where N=IMG_W*IMG_H (default 393218 cycles).
- When done=1 and found=0, min_x/max_x/min_y/max_y read as 0 (output mux), not the internal sentinels.
- While done=0, the outputs show the running accumulator values, with the same no-foreground masking applied.
- Reset asserted mid-scan aborts the scan immediately, and the next release restarts it from pixel 0.
- Out-of-range x/y are impossible by construction; no extra handling is required.

Decomposition:
- Package bbox_pkg holds:
  - state enum {SCAN, LAST, DONE}
  - luma function
  - coordinate-width helper localparams
- Sub-module bbox_pixel_classifier computes the combinational luma and the foreground compare.
- Memory, counters, FSM and accumulators stay in bounding_box_top, so that ram remains reachable at the top hierarchy.

Test Plan:
- IMG_W=8, IMG_H=4, all pixels 000000, pulse rst -> done rises 34 cycles after rst release; found=0; all bbox outputs 0.
- 8x4 image, only (3,2)=FFFFFF -> found=1; min_x=max_x=3; min_y=max_y=2.
- 8x4 image, (1,0)=FFFFFF and (6,3)=808080 -> min_x=1, max_x=6, min_y=0, max_y=3.
- Threshold boundary, THRESH=128: (5,1)=808080 (luma 128) is counted, (2,2)=7F7F7F (luma 127) is ignored -> box 5,5,1,1.
- Reset mid-scan: with the single-pixel image, assert rst at cycle 15 -> done=0 and outputs return to reset values; after release the scan completes with box 3,3,2,2 and done 34 cycles after the second release.
- Default 768x512 image, single foreground pixel at (767,511) -> box 767,767,511,511; done after 393218 cycles.
